ppm_encoder: RTL and testbench

Drone-side consumer of the gesture command bytes. Takes the four 8-bit stick commands (roll, pitch, throttle, yaw; 0..232, center 116) produced by the gesture-mapping blocks. Emits a standard 4-channel PPM frame train on one pin, which drives the RC transmitter trainer port. Commands are snapshotted once per frame, so a pulse never changes width mid-frame.

---
 rtl/ppm_encoder_if.sv | 21 ++
 rtl/ppm_encoder.sv | 121 ++++++++++++
 tb/tb_ppm_encoder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ppm_encoder_if.sv
// Stick-command inputs and PPM train outputs of the encoder.
// master = command source / observer, slave = encoder.
interface ppm_encoder_if;
  logic [7:0] roll;
  logic [7:0] pitch;
  logic [7:0] throttle;
  logic [7:0] yaw;
  logic       ppm;
  logic       frame_start;
  logic [2:0] channel;

  modport master (
    output roll, pitch, throttle, yaw,
    input  ppm, frame_start, channel
  );

  modport slave (
    input  roll, pitch, throttle, yaw,
    output ppm, frame_start, channel
  );
endinterface

// File: rtl/ppm_encoder.sv
// 4-channel PPM frame generator; commands are snapshotted
// at frame cycle 0 so no pulse changes width mid-frame.
module ppm_encoder #(
  parameter int FRAME_CLKS     = 540000,
  parameter int SEP_CLKS       = 8100,
  parameter int MIN_PULSE_CLKS = 27000,
  parameter int STEP_CLKS      = 116,
  parameter int CMD_MAX        = 232
) (
  input  logic         clock,
  input  logic         reset,
  ppm_encoder_if.slave bus
);

  localparam int CW   = $clog2(FRAME_CLKS);
  localparam int WMAX = MIN_PULSE_CLKS + CMD_MAX * STEP_CLKS;
  localparam int WW   = $clog2(WMAX + 1);

  typedef enum logic [1:0] {
    MARK,
    SPACE,
    FMARK,
    SYNC
  } st_e;

  st_e             st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   sc_q, sc_d;
  logic [1:0]      k_q, k_d;
  logic [3:0][7:0] cmd_q, cmd_d;
  logic            ppm_q, ppm_d;
  logic            fs_q, fs_d;
  logic [2:0]      ch_q, ch_d;

  logic [3:0][7:0] raw;
  logic [WW-1:0]   w;
  logic            wrap;

  function automatic logic [7:0] clamp(input logic [7:0] c);
    return (c > 8'(CMD_MAX)) ? 8'(CMD_MAX) : c;
  endfunction

  always_comb begin
    raw   = {bus.yaw, bus.throttle, bus.pitch, bus.roll};
    wrap  = (cnt_q == CW'(FRAME_CLKS - 1));
    w     = WW'(MIN_PULSE_CLKS)
          + WW'(cmd_q[k_q]) * WW'(STEP_CLKS);
    st_d  = st_q;
    cnt_d = cnt_q + CW'(1);
    sc_d  = sc_q + WW'(1);
    k_d   = k_q;
    cmd_d = cmd_q;
    if (wrap) begin
      cnt_d = '0;
      sc_d  = '0;
      k_d   = '0;
      st_d  = MARK;
      for (int i = 0; i < 4; i++) begin
        cmd_d[i] = clamp(raw[i]);
      end
    end else begin
      unique case (st_q)
        MARK: begin
          if (sc_q == WW'(SEP_CLKS - 1)) st_d = SPACE;
        end
        SPACE: begin
          // sc counts the whole slot, mark included
          if (sc_q == w - WW'(1)) begin
            sc_d = '0;
            if (k_q == 2'd3) begin
              st_d = FMARK;
            end else begin
              st_d = MARK;
              k_d  = k_q + 2'd1;
            end
          end
        end
        FMARK: begin
          if (sc_q == WW'(SEP_CLKS - 1)) st_d = SYNC;
        end
        SYNC: begin
          sc_d = sc_q;
        end
        default: st_d = SYNC;
      endcase
    end
    ppm_d = !(st_d == MARK || st_d == FMARK);
    ch_d  = (st_d == FMARK || st_d == SYNC)
          ? 3'd4 : {1'b0, k_d};
    fs_d  = wrap;
  end

  // Reset parks the counter at the last frame cycle so the
  // first clocked edge opens a fresh frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q  <= SYNC;
      cnt_q <= CW'(FRAME_CLKS - 1);
      sc_q  <= '0;
      k_q   <= '0;
      cmd_q <= '0;
      ppm_q <= 1'b1;
      fs_q  <= 1'b0;
      ch_q  <= 3'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      sc_q  <= sc_d;
      k_q   <= k_d;
      cmd_q <= cmd_d;
      ppm_q <= ppm_d;
      fs_q  <= fs_d;
      ch_q  <= ch_d;
    end
  end

  assign bus.ppm         = ppm_q;
  assign bus.frame_start = fs_q;
  assign bus.channel     = ch_q;

endmodule

// File: tb/tb_ppm_encoder.sv
// Bench for ppm_encoder: per-cycle scoreboard from a slot
// boundary model, plus mark-position tables and reset cases.
module tb_ppm_encoder;

  localparam int FR = 2000;

  typedef logic [3:0][7:0]  cmd_t;
  typedef logic [4:0][15:0] marks_t;

  typedef struct packed {
    logic        ppm;
    logic [2:0]  ch;
    logic        fs;
    logic [15:0] n;
  } exp_t;

  typedef struct packed {
    cmd_t   c;
    marks_t m;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  ppm_encoder_if bus ();

  ppm_encoder #(
    .FRAME_CLKS    (2000),
    .SEP_CLKS      (10),
    .MIN_PULSE_CLKS(100),
    .STEP_CLKS     (1),
    .CMD_MAX       (232)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  exp_t sb[$];
  int   edge_pos[$];
  int   bad;
  int   vectors;
  int   miscompares;
  cmd_t cur;
  logic prev_ppm;
  exp_t last_exp;
  logic [4:0] last_act;

  function automatic exp_t model(input int n, input cmd_t c);
    exp_t e;
    int s;
    int w;
    bit done;
    s = 0;
    done = 0;
    e.fs = (n == 0);
    e.n = 16'(n);
    e.ch = 3'd4;
    e.ppm = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (!done) begin
        w = 100 + ((c[k] > 8'd232) ? 232 : int'(c[k]));
        if (n < s + w) begin
          e.ch = 3'(k);
          e.ppm = (n >= s + 10);
          done = 1;
        end else begin
          s += w;
        end
      end
    end
    if (!done) e.ppm = (n >= s + 10);
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic set_cmds(input cmd_t c);
    cur = c;
    bus.roll = c[0];
    bus.pitch = c[1];
    bus.throttle = c[2];
    bus.yaw = c[3];
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (bus.ppm !== e.ppm || bus.channel !== e.ch ||
            bus.frame_start !== e.fs) begin
          bad++;
          last_exp = e;
          last_act = {bus.ppm, bus.channel, bus.frame_start};
        end
        if (prev_ppm === 1'b1 && bus.ppm === 1'b0)
          edge_pos.push_back(int'(e.n));
      end
      prev_ppm = bus.ppm;
    end
  endtask

  task automatic run_frame(input int tag, input int chg_at,
                           input cmd_t cnew, input int stop_at,
                           input bit chk_m, input marks_t m);
    cmd_t snap;
    int b0;
    int e0;
    int got;
    snap = cur;
    b0 = bad;
    e0 = edge_pos.size();
    for (int n = 0; n < FR; n++) begin
      @(posedge clock);
      if (n == stop_at) begin
        #1;
        check($sformatf("f%0d pre-reset ppm", tag), 32'(bus.ppm), 0);
        #1 reset = 1'b0;
        #1;
        check($sformatf("f%0d async ppm", tag), 32'(bus.ppm), 1);
        check($sformatf("f%0d async ch", tag), 32'(bus.channel), 0);
        check($sformatf("f%0d async fs", tag),
              32'(bus.frame_start), 0);
        break;
      end
      sb.push_back(model(n, snap));
      if (n == chg_at) begin
        #1 set_cmds(cnew);
      end
    end
    @(negedge clock);
    #1;
    vectors++;
    if (bad != b0) begin
      miscompares++;
      $display("FAIL f%0d cycles: %0d wrong, expected 0; last at %0d got ppm/ch/fs=%b/%0d/%b expected %b/%0d/%b",
               tag, bad - b0, last_exp.n, last_act[4], last_act[3:1],
               last_act[0], last_exp.ppm, last_exp.ch, last_exp.fs);
    end
    if (stop_at < 0)
      check($sformatf("f%0d falling edges", tag),
            edge_pos.size() - e0, 5);
    if (chk_m) begin
      for (int i = 0; i < 5; i++) begin
        got = (e0 + i < edge_pos.size()) ? edge_pos[e0 + i] : -1;
        check($sformatf("f%0d mark%0d", tag, i), got, 32'(m[i]));
      end
    end
  endtask

  initial begin
    vec_t   tbl[2];
    cmd_t   c116;
    cmd_t   cp0;
    marks_t m116;
    marks_t mp0;
    cmd_t   rc;
    int     hi_bad;

    vectors = 0;
    miscompares = 0;
    bad = 0;
    prev_ppm = 1'b1;
    c116 = {8'd116, 8'd116, 8'd116, 8'd116};
    cp0 = {8'd116, 8'd116, 8'd0, 8'd116};
    m116 = {16'd864, 16'd648, 16'd432, 16'd216, 16'd0};
    mp0 = {16'd748, 16'd532, 16'd316, 16'd216, 16'd0};
    tbl[0].c = c116;
    tbl[0].m = m116;
    tbl[1].c = {8'd116, 8'd255, 8'd232, 8'd0};
    tbl[1].m = {16'd980, 16'd764, 16'd432, 16'd100, 16'd0};

    fork
      monitor();
    join_none

    set_cmds(c116);
    repeat (3) @(negedge clock);
    check("reset ppm", 32'(bus.ppm), 1);
    check("reset ch", 32'(bus.channel), 0);
    check("reset fs", 32'(bus.frame_start), 0);
    reset = 1'b1;
    #1;

    for (int i = 0; i < 2; i++) begin
      set_cmds(tbl[i].c);
      run_frame(i, -1, '0, -1, 1, tbl[i].m);
    end

    // pitch drops mid-frame: only the next frame sees it
    set_cmds(c116);
    run_frame(2, 300, cp0, -1, 1, m116);
    run_frame(3, -1, '0, -1, 1, mp0);

    set_cmds(c116);
    run_frame(4, -1, '0, 220, 0, '0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    run_frame(5, -1, '0, -1, 1, m116);

    reset = 1'b0;
    hi_bad = 0;
    for (int n = 0; n < 3 * FR; n++) begin
      @(negedge clock);
      if (bus.ppm !== 1'b1 || bus.frame_start !== 1'b0 ||
          bus.channel !== 3'd0)
        hi_bad++;
      if (n == FR) set_cmds(c116);
    end
    check("long reset idle", hi_bad, 0);
    set_cmds(tbl[1].c);
    reset = 1'b1;
    #1;
    run_frame(6, -1, '0, -1, 1, tbl[1].m);

    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 4; k++) rc[k] = 8'($urandom_range(0, 255));
      set_cmds(rc);
      run_frame(7 + f, -1, '0, -1, 0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
